// File: rtl/ro_tdc_pkg.sv
// ro_tdc_pkg: shared FSM state type and default widths for the RO/TDC tile.
package ro_tdc_pkg;
    typedef enum logic [1:0] {IDLE, SETTLE, GATE, HOLD} state_t;
    localparam int N_RO_DEF        = 4;
    localparam int CNT_W_DEF       = 8;
    localparam int GATE_W_DEF      = 10;
    localparam int SYNC_STAGES_DEF = 2;
endpackage

// File: rtl/ro_sync_edge.sv
// ro_sync_edge: synchronises an asynchronous RO tap into clk and flags its rising edges.
module ro_sync_edge
    import ro_tdc_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_async,
    input  logic clr,
    output logic edge_o
);
    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d_async};
            prev  <= chain[SYNC_STAGES-1];
        end
    end
    // chain keeps running during clr so it is flushed with the new tap; only the edge is masked
    assign edge_o = ~clr & chain[SYNC_STAGES-1] & ~prev;
endmodule

// File: rtl/ro_gate_counter.sv
// ro_gate_counter: counts rising edges of a selected ring oscillator over a gate window of clk cycles.
module ro_gate_counter
    import ro_tdc_pkg::*;
#(
    parameter int N_RO        = N_RO_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int GATE_W      = GATE_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    localparam int SEL_W      = $clog2(N_RO)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_RO-1:0]   ro_in,
    input  logic [SEL_W-1:0]  sel,
    input  logic [GATE_W-1:0] gate_len,
    input  logic              start,
    output logic              busy,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              valid,
    input  logic              ack
);
    state_t            state;
    logic [SEL_W-1:0]  sel_q;
    logic [GATE_W-1:0] len_q;
    logic [GATE_W-1:0] timer;
    logic              edge_det;
    ro_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_async (ro_in[sel_q]),
        .clr     (state == SETTLE),
        .edge_o  (edge_det)
    );
    assign busy  = state != IDLE;
    assign valid = state == HOLD;
    // timer counts SETTLE down from SYNC_STAGES, then GATE down from len_q-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel_q    <= '0;
            len_q    <= '0;
            timer    <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state    <= SETTLE;
                    sel_q    <= sel;
                    len_q    <= (gate_len == '0) ? GATE_W'(1) : gate_len;
                    timer    <= GATE_W'(SYNC_STAGES);
                    count    <= '0;
                    overflow <= 1'b0;
                end
                SETTLE: begin
                    state <= (timer == '0) ? GATE : SETTLE;
                    timer <= (timer == '0) ? len_q - 1'b1 : timer - 1'b1;
                end
                GATE: begin
                    if (edge_det) begin
                        if (&count) overflow <= 1'b1;
                        else count <= count + 1'b1;
                    end
                    state <= (timer == '0) ? HOLD : GATE;
                    timer <= timer - 1'b1;
                end
                HOLD: if (ack) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ro_gate_counter.sv
// tb_ro_gate_counter: randomized self-checking bench against a sampled-waveform edge-count model.
module tb_ro_gate_counter;
    localparam int S = 2;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] ro_in = '0;
    logic [1:0] sel = '0;
    logic [9:0] gate_len = '0;
    logic       start = 1'b0;
    logic       ack = 1'b0;
    logic       busy, overflow, valid;
    logic [7:0] count;
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_ack = 0;
    int hp[4];
    int ph[4];
    logic [3:0] hist [0:131071];

    ro_gate_counter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ro_in    (ro_in),
        .sel      (sel),
        .gate_len (gate_len),
        .start    (start),
        .busy     (busy),
        .count    (count),
        .overflow (overflow),
        .valid    (valid),
        .ack      (ack)
    );

    always #5 clk = ~clk;

    // value of every RO as seen by the DUT at each rising edge
    always @(posedge clk) begin
        hist[cyc] <= ro_in;
        cyc <= cyc + 1;
    end

    // each RO toggles every hp[i] clk cycles (0 = constant)
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (hp[i] != 0) begin
                if (ph[i] >= hp[i] - 1) begin
                    ro_in[i] <= ~ro_in[i];
                    ph[i] <= 0;
                end else begin
                    ph[i] <= ph[i] + 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // rising transitions of tap s in the len samples following the first post-accept sample
    function automatic int model_count(input int s, input int a, input int l);
        int n = 0;
        for (int j = a + 2; j <= a + 1 + l; j++)
            if (hist[j][s] && !hist[j-1][s]) n++;
        return n;
    endfunction

    task automatic run(input int s, input int len, input int a, input bit poke);
        int l;
        int raw;
        int exp_c;
        l = (len == 0) ? 1 : len;
        for (int i = 0; i <= S + l; i++) begin
            if (i > 0) @(negedge clk);
            check("busy_run", busy, 1);
            check("valid_early", valid, 0);
            if (poke && i == S + 1) begin
                sel = 2'($urandom);
                gate_len = 10'($urandom);
                ack = 1'b1;
            end
        end
        ack = 1'b0;
        @(negedge clk);
        raw = model_count(s, a, l);
        exp_c = (raw > 255) ? 255 : raw;
        check("valid_rise", valid, 1);
        check("busy_hold", busy, 1);
        check("count", count, exp_c);
        check("overflow", overflow, 32'(raw > 255));
        repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            check("count_hold", count, exp_c);
            check("valid_hold", valid, 1);
        end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        last_ack = cyc - 1;
        check("valid_ack", valid, 0);
        check("busy_ack", busy, 0);
        check("count_keep", count, exp_c);
    endtask

    task automatic meas(input int s, input int len, input bit poke);
        sel = 2'(s);
        gate_len = 10'(len);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        run(s, len, cyc - 1, poke);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            hp[i] = 0;
            ph[i] = 0;
        end
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        check("rst_count", count, 0);
        check("rst_ovf", overflow, 0);
        rst_n = 1'b1;
        @(negedge clk);
        hp[0] = 2;
        repeat (8) @(negedge clk);
        meas(0, 100, 0);
        check("s1_range", 32'(count >= 24 && count <= 26), 1);
        hp[0] = 1;
        meas(0, 1000, 0);
        check("s2_sat", count, 255);
        check("s2_ovf", overflow, 1);
        hp[0] = 0;
        hp[2] = 2;
        repeat (4) @(negedge clk);
        meas(1, 40, 0);
        check("s3_idle_tap", count, 0);
        meas(2, 40, 0);
        check("s3_range", 32'(count >= 9 && count <= 11), 1);
        hp[2] = 0;
        hp[0] = 2;
        meas(0, 0, 0);
        check("s4_range", 32'(count <= 1), 1);
        hp[1] = 3;
        sel = 2'd0;
        gate_len = 10'd30;
        start = 1'b1;
        @(negedge clk);
        run(0, 30, cyc - 1, 1);
        sel = 2'd1;
        gate_len = 10'd20;
        @(negedge clk);
        check("s5_restart", busy, 1);
        check("s5_restart_edge", 32'(cyc - 1 - last_ack), 1);
        start = 1'b0;
        run(1, 20, cyc - 1, 0);
        sel = 2'd0;
        gate_len = 10'd100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (S + 10) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("s6_busy", busy, 0);
        check("s6_valid", valid, 0);
        check("s6_count", count, 0);
        check("s6_ovf", overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        meas(0, 100, 0);
        check("s6_range", 32'(count >= 24 && count <= 26), 1);
        repeat (25) begin
            int s;
            int len;
            for (int i = 0; i < 4; i++) hp[i] = $urandom_range(0, 5);
            s = $urandom_range(0, 3);
            len = ($urandom_range(0, 5) == 0) ? $urandom_range(300, 600) : $urandom_range(0, 60);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            meas(s, len, 1'($urandom_range(0, 1)));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
